mc_control_fsm: RTL

- Multicycle main control unit for the MIPS-subset CPU; sits directly upstream of the ALU and datapath.
- Sequences each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath enable and mux select, plus the 4-bit ALU operation code consumed by the ALU (AND/OR/ADD/SUB/SLT/NOR/NOT).
- Moore machine: outputs are decoded from the state register only, except alu_ctl in execute states, which is also decoded from the latched funct.

---
 rtl/mc_ctrl_pkg.sv | 74 +++++++
 rtl/mc_control_fsm_alu_decoder.sv | 36 +++
 rtl/mc_control_fsm.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path.
// Holds the FSM state encoding, opcode/funct constants, ALU operation codes
// (also consumed by the ALU itself) and the datapath mux select codes.
package mc_ctrl_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [3:0] {
        ST_RST       = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXEC_R    = 4'd3,
        ST_WB_R      = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_WB_MEM    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_EXEC_I    = 4'd11,
        ST_WB_I      = 4'd12,
        ST_ILLEGAL   = 4'd13
    } state_t;

    // Opcodes (instruction [31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // R-type funct codes (instruction [5:0])
    localparam logic [5:0] FN_ADD         = 6'b100000;
    localparam logic [5:0] FN_SUB         = 6'b100010;
    localparam logic [5:0] FN_AND         = 6'b100100;
    localparam logic [5:0] FN_OR          = 6'b100101;
    localparam logic [5:0] FN_SLT         = 6'b101010;
    localparam logic [5:0] FN_NOR         = 6'b100111;
    localparam logic [5:0] FN_NOT_DEFAULT = 6'b111000;

    // ALU operation codes
    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'b1101;

    // ALU B operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // State reached from DECODE for a given opcode.
    function automatic state_t dispatch_opcode(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return ST_EXEC_R;
            OP_LW, OP_SW: return ST_MEM_ADDR;
            OP_BEQ:       return ST_BRANCH;
            OP_J:         return ST_JUMP;
            OP_ADDI:      return ST_EXEC_I;
            default:      return ST_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_decoder.sv
// alu_decoder: combinational map of an R-type funct field to an ALU code.
// Ports:
//   funct_i       - R-type funct field
//   alu_ctl_o     - ALU operation code (ADD when funct is unknown)
//   funct_legal_o - 1 when funct_i is a supported operation
module alu_decoder
    import mc_ctrl_pkg::*;
#(
    parameter int         ALU_CTL_W = ALU_W,
    parameter logic [5:0] NOT_FUNCT = FN_NOT_DEFAULT
) (
    input  logic [5:0]           funct_i,
    output logic [ALU_CTL_W-1:0] alu_ctl_o,
    output logic                 funct_legal_o
);

    always_comb begin
        alu_ctl_o     = ALU_CTL_W'(ALU_ADD);
        funct_legal_o = 1'b1;
        // NOT_FUNCT is configurable, so it is matched ahead of the fixed table.
        if (funct_i == NOT_FUNCT) begin
            alu_ctl_o = ALU_CTL_W'(ALU_NOT);
        end else begin
            case (funct_i)
                FN_ADD:  alu_ctl_o = ALU_CTL_W'(ALU_ADD);
                FN_SUB:  alu_ctl_o = ALU_CTL_W'(ALU_SUB);
                FN_AND:  alu_ctl_o = ALU_CTL_W'(ALU_AND);
                FN_OR:   alu_ctl_o = ALU_CTL_W'(ALU_OR);
                FN_SLT:  alu_ctl_o = ALU_CTL_W'(ALU_SLT);
                FN_NOR:  alu_ctl_o = ALU_CTL_W'(ALU_NOR);
                default: funct_legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle main control unit for the MIPS-subset CPU.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and drives every datapath enable, mux select and the ALU operation code.
// Ports:
//   clk, rst_n         - clock (rising edge), asynchronous active-low reset
//   opcode, funct      - instruction register fields (valid from DECODE)
//   alu_zero           - ALU zero flag (branch decision is gated externally)
//   pc_write .. pc_source, alu_ctl - datapath controls (Moore outputs)
//   instr_done         - pulse in the last state of each instruction
//   illegal            - sticky illegal opcode/funct flag
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int         ALU_CTL_W = ALU_W,
    parameter logic [5:0] NOT_FUNCT = FN_NOT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 alu_zero,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 mem_to_reg,
    output logic                 reg_dst,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_source,
    output logic [ALU_CTL_W-1:0] alu_ctl,
    output logic                 instr_done,
    output logic                 illegal
);

    state_t     state_q, state_d;
    logic [5:0] opcode_q;
    logic [5:0] funct_q;
    logic       illegal_q;

    logic [ALU_CTL_W-1:0] r_alu_ctl;
    logic                 r_funct_legal;

    alu_decoder #(
        .ALU_CTL_W (ALU_CTL_W),
        .NOT_FUNCT (NOT_FUNCT)
    ) u_alu_decoder (
        .funct_i       (funct_q),
        .alu_ctl_o     (r_alu_ctl),
        .funct_legal_o (r_funct_legal)
    );

    // Async reset forces RST, whose decode drives every strobe low at once,
    // so an aborted memory write cannot linger until the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RST;
            opcode_q  <= '0;
            funct_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                opcode_q <= opcode;
                funct_q  <= funct;
            end
            if (state_d == ST_ILLEGAL) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_B;
        pc_source     = PCSRC_ALU;
        alu_ctl       = ALU_CTL_W'(ALU_ADD);
        instr_done    = 1'b0;

        case (state_q)
            ST_RST: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target precomputed here while the opcode is decoded.
                alu_src_b = SRCB_IMM_SH;
                state_d   = dispatch_opcode(opcode);
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctl   = r_alu_ctl;
                state_d   = r_funct_legal ? ST_WB_R : ST_ILLEGAL;
            end
            ST_WB_R: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode_q == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                i_or_d   = 1'b1;
                mem_read = 1'b1;
                state_d  = ST_WB_MEM;
            end
            ST_WB_MEM: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                i_or_d     = 1'b1;
                mem_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_ctl       = ALU_CTL_W'(ALU_SUB);
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = ST_WB_I;
            end
            ST_WB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ILLEGAL: state_d = ST_ILLEGAL;
            // Unused encodings are treated as a corrupted sequence.
            default: state_d = ST_ILLEGAL;
        endcase
    end

    // alu_zero is applied to pc_write_cond by the datapath, not here.
    logic unused_zero;
    assign unused_zero = alu_zero;

    assign illegal = illegal_q;

endmodule
